// File: rtl/ov7670_capture_writer_pkg.sv
// Constants and types shared by the frame buffer write side and the VGA read side.
// Combinational definitions only: no latency, no flow control.
package ov7670_capture_writer_pkg;

   localparam int H_PIXELS_DEF = 320;
   localparam int V_LINES_DEF  = 240;
   localparam int COORD_W      = 10;
   localparam int COLOR_W      = 4;
   localparam int CAM_BUS_W    = 11;   // {pclk, vsync, href, data[7:0]}

   typedef enum logic [2:0] {
      WAIT_VSYNC,
      VSYNC_HIGH,
      LINE_IDLE,
      BYTE2,
      BYTE1
   } cap_state_t;

   typedef struct packed {
      logic [COLOR_W-1:0] red;
      logic [COLOR_W-1:0] green;
      logic [COLOR_W-1:0] blue;
   } rgb444_t;

endpackage

// File: rtl/ov7670_capture_writer_cam_input_sync.sv
// Brings the camera bus into the clk domain and flags PCLK rising edges.
// Latency SYNC_STAGES clk for the bundle, one more for the edge history; no backpressure.
module cam_input_sync
   import ov7670_capture_writer_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CAM_BUS_W-1:0] raw,
   output logic [CAM_BUS_W-2:0] aligned,
   output logic                 pclk_rise
);

   logic [CAM_BUS_W-1:0] stage [SYNC_STAGES];
   logic                 pclk_hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
         pclk_hist <= 1'b0;
      end else begin
         stage[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
         pclk_hist <= stage[SYNC_STAGES-1][CAM_BUS_W-1];
      end
   end

   // vsync/href/data leave on the same cycle as the edge they were captured with
   assign aligned   = stage[SYNC_STAGES-1][CAM_BUS_W-2:0];
   assign pclk_rise = stage[SYNC_STAGES-1][CAM_BUS_W-1] & ~pclk_hist;

endmodule

// File: rtl/ov7670_capture_writer.sv
// Pairs OV7670 RGB444 bytes into pixels and drives the frame buffer write port.
// Write strobe one clk after the second byte's PCLK edge is seen; no backpressure (buffer always accepts).
module ov7670_capture_writer
   import ov7670_capture_writer_pkg::*;
#(
   parameter int H_PIXELS    = H_PIXELS_DEF,
   parameter int V_LINES     = V_LINES_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               capture_en,
   input  logic               cam_pclk,
   input  logic               cam_vsync,
   input  logic               cam_href,
   input  logic [7:0]         cam_data,
   output logic               write_enable,
   output logic [COORD_W-1:0] addr_x,
   output logic [COORD_W-1:0] addr_y,
   output logic [COLOR_W-1:0] vgaRed,
   output logic [COLOR_W-1:0] vgaGreen,
   output logic [COLOR_W-1:0] vgaBlue,
   output logic               frame_done,
   output logic               frame_error
);

   localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(H_PIXELS);
   localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(V_LINES);

   logic                 rst_sync_n;
   logic [CAM_BUS_W-2:0] cam_bus;
   logic                 pclk_rise;
   logic                 vsync, href;
   logic [7:0]           data;

   cap_state_t           state, state_nx;
   logic [COORD_W-1:0]   x, y;
   logic [COLOR_W-1:0]   red_q;
   rgb444_t              pix_q;
   logic                 x_in, y_in;
   logic                 clr_frame, take_red, pix_in, line_end, set_err, done_pls;

   // assert asynchronously, release on a clk edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_n <= 1'b0;
      else          rst_sync_n <= 1'b1;
   end

   cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_sync_n),
      .raw       ({cam_pclk, cam_vsync, cam_href, cam_data}),
      .aligned   (cam_bus),
      .pclk_rise (pclk_rise)
   );

   assign vsync = cam_bus[9];
   assign href  = cam_bus[8];
   assign data  = cam_bus[7:0];
   assign x_in  = (x < X_LIMIT);
   assign y_in  = (y < Y_LIMIT);

   always_comb begin
      state_nx  = state;
      clr_frame = 1'b0;
      take_red  = 1'b0;
      pix_in    = 1'b0;
      line_end  = 1'b0;
      set_err   = 1'b0;
      done_pls  = 1'b0;
      if (pclk_rise) begin
         unique case (state)
            WAIT_VSYNC: if (vsync) state_nx = VSYNC_HIGH;
            VSYNC_HIGH: begin
               if (!vsync) begin
                  if (capture_en) begin
                     state_nx  = LINE_IDLE;
                     clr_frame = 1'b1;
                  end else begin
                     state_nx = WAIT_VSYNC;
                  end
               end
            end
            LINE_IDLE: begin
               if (vsync) begin
                  done_pls = (y != '0);
                  state_nx = VSYNC_HIGH;
               end else if (href) begin
                  take_red = 1'b1;
                  state_nx = BYTE2;
               end
            end
            BYTE2: begin
               if (vsync) begin
                  set_err  = 1'b1;
                  state_nx = VSYNC_HIGH;
               end else if (href) begin
                  pix_in   = 1'b1;
                  state_nx = BYTE1;
               end else begin
                  // line ended on a half pixel: drop it but still advance the line
                  set_err  = 1'b1;
                  line_end = 1'b1;
                  state_nx = LINE_IDLE;
               end
            end
            BYTE1: begin
               if (vsync) begin
                  set_err  = 1'b1;
                  state_nx = VSYNC_HIGH;
               end else if (href) begin
                  take_red = 1'b1;
                  state_nx = BYTE2;
               end else begin
                  line_end = 1'b1;
                  state_nx = LINE_IDLE;
               end
            end
            default: state_nx = WAIT_VSYNC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state        <= WAIT_VSYNC;
         x            <= '0;
         y            <= '0;
         red_q        <= '0;
         pix_q        <= '0;
         write_enable <= 1'b0;
         addr_x       <= '0;
         addr_y       <= '0;
         frame_done   <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         state        <= state_nx;
         write_enable <= 1'b0;
         frame_done   <= done_pls;
         if (clr_frame) begin
            x           <= '0;
            y           <= '0;
            frame_error <= 1'b0;
         end
         if (take_red) red_q <= data[3:0];
         if (pix_in) begin
            if (x_in && y_in) begin
               write_enable <= 1'b1;
               addr_x       <= x;
               addr_y       <= y;
               pix_q        <= '{red: red_q, green: data[7:4], blue: data[3:0]};
            end else if (y_in) begin
               frame_error <= 1'b1;
            end
            if (x_in) x <= x + 1'b1;
         end
         if (line_end) begin
            x <= '0;
            if (y_in) y <= y + 1'b1;
         end
         if (set_err) frame_error <= 1'b1;
      end
   end

   assign vgaRed   = pix_q.red;
   assign vgaGreen = pix_q.green;
   assign vgaBlue  = pix_q.blue;

endmodule

// File: tb/tb_ov7670_capture_writer.sv
// Frame-level bench on a shrunken 8x4 buffer: table of frames plus abort and reset sequences.
module tb_ov7670_capture_writer;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int SS = 2;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } pix_t;

   typedef struct {
      bit en_start;
      bit en_mid;
      int lines;
      int nbytes;
      int pat;
      int exp_wr;
      int exp_done;
      int exp_err;
   } row_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       capture_en = 1'b0;
   logic       cam_pclk = 1'b0;
   logic       cam_vsync = 1'b0;
   logic       cam_href = 1'b0;
   logic [7:0] cam_data = 8'h00;
   logic       write_enable, frame_done, frame_error;
   logic [9:0] addr_x, addr_y;
   logic [3:0] vgaRed, vgaGreen, vgaBlue;

   int   checks = 0;
   int   failures = 0;
   pix_t exp_q[$];
   pix_t act_q[$];
   int   rd_ptr = 0;
   int   wr_total = 0;
   int   done_total = 0;
   int   b2b_count = 0;
   int   hold_viol = 0;
   bit   prev_we = 1'b0;
   bit   prev_rst = 1'b0;
   pix_t prev_out = '0;
   row_t tbl[9];

   ov7670_capture_writer #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset_n(reset_n), .capture_en(capture_en),
      .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
      .write_enable(write_enable), .addr_x(addr_x), .addr_y(addr_y),
      .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
      .frame_done(frame_done), .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (write_enable) begin
         act_q.push_back({addr_x, addr_y, vgaRed, vgaGreen, vgaBlue});
         wr_total <= wr_total + 1;
         if (prev_we) b2b_count <= b2b_count + 1;
      end
      if (frame_done) done_total <= done_total + 1;
      if (reset_n && prev_rst && !write_enable && ({addr_x, addr_y, vgaRed, vgaGreen, vgaBlue} != prev_out))
         hold_viol <= hold_viol + 1;
      prev_we  <= write_enable;
      prev_rst <= reset_n;
      prev_out <= {addr_x, addr_y, vgaRed, vgaGreen, vgaBlue};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pclk_cycle(input logic vs, input logic hr, input logic [7:0] d);
      cam_vsync = vs;
      cam_href  = hr;
      cam_data  = d;
      #21 cam_pclk = 1'b1;
      #21 cam_pclk = 1'b0;
   endtask

   task automatic send_line(input int nbytes, input int pat, input bit armed, input int li);
      logic [3:0] r, g, b, up;
      r = '0;
      for (int i = 0; i < nbytes; i++) begin
         if (i % 2 == 0) begin
            if (pat == 0) begin r = 4'hA; up = 4'h0; end
            else begin r = 4'($urandom); up = 4'($urandom); end
            pclk_cycle(1'b0, 1'b1, {up, r});
         end else begin
            if (pat == 0) begin g = 4'h5; b = 4'hC; end
            else begin g = 4'($urandom); b = 4'($urandom); end
            pclk_cycle(1'b0, 1'b1, {g, b});
            if (armed && (i / 2) < H && li < V)
               exp_q.push_back({10'(i / 2), 10'(li), r, g, b});
         end
      end
   endtask

   task automatic drain();
      pix_t a, e;
      while (rd_ptr < act_q.size()) begin
         a = act_q[rd_ptr];
         rd_ptr++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got %h expected none", a);
         end else begin
            e = exp_q.pop_front();
            chk("pixel", a, e);
         end
      end
      chk("missing_writes", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic frame_start(input bit en_start, input bit en_mid, output bit armed);
      capture_en = en_start;
      repeat (3) pclk_cycle(1'b1, 1'b0, 8'h00);
      armed = en_start;
      repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
      capture_en = en_mid;
   endtask

   task automatic run_row(input row_t r, input int idx);
      int w0, d0;
      bit armed;
      w0 = wr_total;
      d0 = done_total;
      frame_start(r.en_start, r.en_mid, armed);
      for (int li = 0; li < r.lines; li++) begin
         send_line(r.nbytes, r.pat, armed, li);
         repeat (3) pclk_cycle(1'b0, 1'b0, 8'h00);
      end
      repeat (2) pclk_cycle(1'b1, 1'b0, 8'h00);
      repeat (10) @(negedge clk);
      drain();
      chk($sformatf("row%0d_writes", idx), wr_total - w0, r.exp_wr);
      chk($sformatf("row%0d_frame_done", idx), done_total - d0, r.exp_done);
      chk($sformatf("row%0d_frame_error", idx), frame_error, r.exp_err);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, d0;
      bit armed;
      logic [3:0] r, g, b;

      //             en0 en1 lines bytes pat  wr done err
      tbl[0] = '{1, 1, 4, 16, 0, 32, 1, 0};
      tbl[1] = '{1, 1, 4, 18, 1, 32, 1, 1};   // 9 pixels per line
      tbl[2] = '{1, 1, 3, 16, 1, 24, 1, 0};   // error cleared by new frame
      tbl[3] = '{1, 1, 2, 15, 1, 14, 1, 1};   // odd byte count
      tbl[4] = '{1, 1, 6, 16, 1, 32, 1, 0};   // extra lines dropped silently
      tbl[5] = '{0, 1, 4, 16, 1,  0, 0, 0};   // enable raised mid-frame
      tbl[6] = '{1, 0, 4, 16, 0, 32, 1, 0};   // enable dropped mid-frame
      tbl[7] = '{0, 0, 4, 16, 1,  0, 0, 0};
      tbl[8] = '{1, 1, 2,  4, 1,  4, 1, 0};

      repeat (3) @(negedge clk);
      chk("reset_outputs", {write_enable, addr_x, addr_y, vgaRed, vgaGreen, vgaBlue, frame_done, frame_error}, 64'h0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_release_outputs", {write_enable, addr_x, addr_y, vgaRed, vgaGreen, vgaBlue, frame_done, frame_error}, 64'h0);
      repeat (3) pclk_cycle(1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 9; i++) run_row(tbl[i], i);

      // vsync rising in the middle of a line aborts it without frame_done
      w0 = wr_total;
      d0 = done_total;
      frame_start(1'b1, 1'b1, armed);
      send_line(16, 1, armed, 0);
      repeat (3) pclk_cycle(1'b0, 1'b0, 8'h00);
      send_line(6, 1, armed, 1);
      pclk_cycle(1'b1, 1'b1, 8'h33);
      repeat (2) pclk_cycle(1'b1, 1'b0, 8'h00);
      repeat (10) @(negedge clk);
      drain();
      chk("abort_writes", wr_total - w0, 11);
      chk("abort_frame_done", done_total - d0, 0);
      chk("abort_frame_error", frame_error, 1);
      run_row(tbl[0], 100);

      // reset pulse in the middle of a line
      frame_start(1'b1, 1'b1, armed);
      for (int p = 0; p < 4; p++) begin
         r = 4'($urandom); g = 4'($urandom); b = 4'($urandom);
         pclk_cycle(1'b0, 1'b1, {4'h0, r});
         pclk_cycle(1'b0, 1'b1, {g, b});
         exp_q.push_back({10'(p), 10'd0, r, g, b});
      end
      repeat (8) @(negedge clk);
      drain();
      w0 = wr_total;
      reset_n = 1'b0;
      #1;
      chk("reset_async_outputs", {write_enable, addr_x, addr_y, vgaRed, vgaGreen, vgaBlue, frame_done, frame_error}, 64'h0);
      repeat (3) begin
         @(negedge clk);
         chk("reset_hold_outputs", {write_enable, addr_x, addr_y, vgaRed, vgaGreen, vgaBlue, frame_done, frame_error}, 64'h0);
      end
      reset_n = 1'b1;
      send_line(8, 1, 1'b0, 0);
      repeat (3) pclk_cycle(1'b0, 1'b0, 8'h00);
      send_line(16, 1, 1'b0, 1);
      repeat (3) pclk_cycle(1'b0, 1'b0, 8'h00);
      repeat (10) @(negedge clk);
      drain();
      chk("post_reset_writes", wr_total - w0, 0);
      run_row(tbl[0], 200);

      chk("back_to_back_writes", b2b_count, 0);
      chk("output_hold_violations", hold_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ov7670_capture_writer.md
# ov7670_capture_writer

- Writer end of the 320x240 RGB444 frame buffer.
- Samples the raw OV7670 parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain.
- Pairs bytes into RGB444 pixels and produces one write strobe per pixel, with x/y coordinates and 4-bit colour channels.
- Its outputs connect directly to the frame buffer's write port (write_enable, porta_addr_x/y, porta_vgaRed/Green/Blue).

## Interface
Parameters:
- H_PIXELS, 320, pixels accepted per line; later pixels dropped
- V_LINES, 240, lines accepted per frame; later lines dropped
- SYNC_STAGES, 2, synchronizer flops on every camera input (min 2)

Ports:
- clk  in  1  system clock; must be ≥4x camera PCLK
- reset_n  in  1  asynchronous, active-low reset
- capture_en  in  1  level; sampled only at frame start; 0 freezes the buffer contents
- cam_pclk  in  1  camera pixel clock, asynchronous to clk
- cam_vsync  in  1  camera frame sync, active-high
- cam_href  in  1  camera line valid, active-high
- cam_data  in  8  camera byte bus
- write_enable  out  1  one-clk pulse per completed pixel
- addr_x  out  10  pixel column 0..H_PIXELS-1
- addr_y  out  10  pixel row 0..V_LINES-1
- vgaRed, vgaGreen, vgaBlue  out  4 each  pixel colour
- frame_done  out  1  one-clk pulse after the last pixel of an accepted frame
- frame_error  out  1  sticky; cleared at next frame start

## Operation
- All four camera inputs pass through SYNC_STAGES flops, then one history flop.
- pclk_rise = synced pclk & ~history. Data, href and vsync are consumed on the same delay, so they stay aligned with pclk_rise.
- State machine (all transitions occur only on pclk_rise cycles, except reset):
  - WAIT_VSYNC: wait for vsync=1 → VSYNC_HIGH.
  - VSYNC_HIGH: on vsync=0, go to LINE_IDLE if capture_en=1, else stay in WAIT_VSYNC. Entry to LINE_IDLE clears y=0, x=0 and frame_error.
  - LINE_IDLE: href=1 → latch data[3:0] as red, go to BYTE2. vsync=1 → emit frame_done if y≥1, go to VSYNC_HIGH.
  - BYTE2: href=1 → take data[7:4] as green, data[3:0] as blue, go to BYTE1; pixel completes if x<H_PIXELS and y<V_LINES. href=0 → discard the half pixel, set frame_error, go to LINE_IDLE.
  - BYTE1: href=1 → latch red, go to BYTE2. href=0 → end of line: y++ (saturates at V_LINES), x=0, go to LINE_IDLE.
- On pixel completion, register addr_x=x, addr_y=y and the three colours, and pulse write_enable. Then x++; x saturates at H_PIXELS.
- Line with more than H_PIXELS pixels: extra pixels produce no write and set frame_error. Frame with more than V_LINES lines: extra lines produce no writes, no error.
- vsync=1 seen in BYTE1/BYTE2 (mid-line): abort the line, set frame_error, go to VSYNC_HIGH. No frame_done pulse.
- Simultaneous href fall and vsync rise: vsync wins.
- A capture_en change during a frame takes effect at the next frame start.

## Timing
- Reset: state=WAIT_VSYNC; x=y=0; all outputs 0; synchronizers cleared.
- Deassertion of reset_n is synchronized internally; the block is first active one clk after release.
- write_enable rises on the clk edge after the pclk_rise cycle of the second byte. Latency from the raw PCLK edge is SYNC_STAGES+2 clk, ±1 clk for phase.
- addr_x/addr_y/colours change only with write_enable and hold until the next write.
- frame_done rises on the clk edge after the pclk_rise that observes vsync=1 in LINE_IDLE.
- At most one write_enable per 2 PCLK periods; never on consecutive clk cycles.

## Structure
- Shared package holds: H_PIXELS/V_LINES defaults, the 10-bit coordinate width, the 4-bit colour width, and the state encoding. The VGA read side uses the same constants.
- Sub-module cam_input_sync: parameterised SYNC_STAGES synchronizer plus history flop for the 11-bit bundle {pclk, vsync, href, data}. Outputs the aligned bundle and pclk_rise.
- The FSM, counters and output registers live in the top module.

## Test plan
- Full frame, clk 100 MHz, PCLK 24 MHz, 240 lines × 640 bytes, byte pair (0x0A, 0x5C) → 76800 writes. First write at (0,0) with R=A, G=5, B=C. Last at (319,239). One frame_done; frame_error=0.
- Line of 642 bytes → 320 writes for that line, x never exceeds 319, frame_error=1. Next frame clears it.
- Line of 639 bytes (odd) → 319 writes; half pixel dropped; frame_error=1; next line writes at x=0, y+1.
- vsync asserted mid-line 100 → no frame_done. Next frame restarts at (0,0).
- capture_en=0 before vsync → zero writes for that frame. capture_en raised mid-frame → writes start only at the next frame.
- reset_n pulsed low for 3 clk mid-line → all outputs 0 during reset. After release, no writes until a full vsync high→low sequence is seen.
